// File: rtl/kernel_pos_seq.sv
// Raster position sequencer for an IMG_W x IMG_H frame; each position carries a
// registered border code (select) for a downstream kernel weight mux. Optional stall counter: KSEQ_STALL_CNT_EN.
module kernel_pos_seq #(
    parameter int IMG_W = 8,
    parameter int IMG_H = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    input  logic        out_ready,
    output logic        out_valid,
    output logic [3:0]  select,
    output logic [7:0]  col,
    output logic [7:0]  row,
    output logic        last,
    output logic        busy,
`ifdef KSEQ_STALL_CNT_EN
    output logic        done,
    output logic [15:0] stall_cnt
`else
    output logic        done
`endif
);

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    localparam logic [7:0] COL_MAX = 8'(IMG_W - 1);
    localparam logic [7:0] ROW_MAX = 8'(IMG_H - 1);

    state_t     state, state_nxt;
    logic [7:0] col_nxt, row_nxt;
    logic [7:0] col_inc, row_inc;
    logic [3:0] sel_nxt;
    logic       last_nxt;
    logic       hs;

    function automatic logic [3:0] encode(input logic [7:0] c, input logic [7:0] r);
        logic c0, cl, r0, rl;
        c0 = (c == '0);
        cl = (c == COL_MAX);
        r0 = (r == '0);
        rl = (r == ROW_MAX);
        if (r0 && c0)      return 4'b0001;
        else if (r0 && cl) return 4'b0010;
        else if (rl && c0) return 4'b0011;
        else if (rl && cl) return 4'b0100;
        else if (cl)       return 4'b0101;
        else if (c0)       return 4'b0110;
        else if (r0)       return 4'b0111;
        else if (rl)       return 4'b1000;
        else               return 4'b0000;
    endfunction

    assign hs      = out_valid & out_ready;
    assign col_inc = (col == COL_MAX) ? 8'd0 : col + 8'd1;
    assign row_inc = (col == COL_MAX) ? row + 8'd1 : row;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Position registers are cleared whenever the FSM leaves SCAN so IDLE always shows reset values.
    always_comb begin
        state_nxt = state;
        col_nxt   = col;
        row_nxt   = row;
        sel_nxt   = select;
        last_nxt  = last;
        case (state)
            IDLE: begin
                if (start && !abort) begin
                    state_nxt = SCAN;
                    col_nxt   = 8'd0;
                    row_nxt   = 8'd0;
                    sel_nxt   = encode(8'd0, 8'd0);
                    last_nxt  = 1'b0;
                end
            end
            SCAN: begin
                if (abort || (hs && last)) begin
                    state_nxt = abort ? IDLE : DONE;
                    col_nxt   = 8'd0;
                    row_nxt   = 8'd0;
                    sel_nxt   = 4'b0000;
                    last_nxt  = 1'b0;
                end else if (hs) begin
                    col_nxt  = col_inc;
                    row_nxt  = row_inc;
                    sel_nxt  = encode(col_inc, row_inc);
                    last_nxt = (col_inc == COL_MAX) && (row_inc == ROW_MAX);
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
                col_nxt   = 8'd0;
                row_nxt   = 8'd0;
                sel_nxt   = 4'b0000;
                last_nxt  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col    <= 8'd0;
            row    <= 8'd0;
            select <= 4'b0000;
            last   <= 1'b0;
        end else begin
            col    <= col_nxt;
            row    <= row_nxt;
            select <= sel_nxt;
            last   <= last_nxt;
        end
    end

    assign out_valid = (state == SCAN);
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);

`ifdef KSEQ_STALL_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= 16'd0;
        end else if (abort || (state == IDLE && start)) begin
            stall_cnt <= 16'd0;
        end else if (out_valid && !out_ready && stall_cnt != 16'hFFFF) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_kernel_pos_seq.sv
// Directed bench for kernel_pos_seq: 4x3 and 2x2 instances, expected positions queued at start.
module tb_kernel_pos_seq;

    typedef struct packed {
        logic [3:0] sel;
        logic [7:0] col;
        logic [7:0] row;
        logic       last;
    } pos_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       out_ready = 1'b1;
    logic       out_valid, last, busy, done;
    logic [3:0] select;
    logic [7:0] col, row;

    logic       start_b = 1'b0;
    logic       abort_b = 1'b0;
    logic       ready_b = 1'b1;
    logic       valid_b, last_b, busy_b, done_b;
    logic [3:0] select_b;
    logic [7:0] col_b, row_b;
`ifdef KSEQ_STALL_CNT_EN
    logic [15:0] stall_cnt, stall_cnt_b;
`endif

    pos_t sbq[$];
    pos_t qb[$];
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    kernel_pos_seq #(.IMG_W(4), .IMG_H(3)) dut_a (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .out_ready(out_ready),
        .out_valid(out_valid), .select(select), .col(col), .row(row),
        .last(last), .busy(busy),
`ifdef KSEQ_STALL_CNT_EN
        .done(done), .stall_cnt(stall_cnt)
`else
        .done(done)
`endif
    );

    kernel_pos_seq #(.IMG_W(2), .IMG_H(2)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .abort(abort_b), .out_ready(ready_b),
        .out_valid(valid_b), .select(select_b), .col(col_b), .row(row_b),
        .last(last_b), .busy(busy_b),
`ifdef KSEQ_STALL_CNT_EN
        .done(done_b), .stall_cnt(stall_cnt_b)
`else
        .done(done_b)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_frame_a();
        int   tab[12] = '{1, 7, 7, 2, 6, 0, 0, 5, 3, 8, 8, 4};
        pos_t p;
        for (int i = 0; i < 12; i++) begin
            p.sel  = 4'(tab[i]);
            p.col  = 8'(i % 4);
            p.row  = 8'(i / 4);
            p.last = (i == 11);
            sbq.push_back(p);
        end
    endtask

    task automatic check_hs(output bit was_last);
        pos_t e;
        was_last = 1'b0;
        if (sbq.size() == 0) begin
            chk("sb_underflow", 32'd1, 32'd0);
        end else begin
            e = sbq.pop_front();
            chk("hs_sel", select, e.sel);
            chk("hs_col", col, e.col);
            chk("hs_row", row, e.row);
            chk("hs_last", last, e.last);
            was_last = e.last;
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_valid"}, out_valid, 0);
        chk({tag, "_sel"}, select, 0);
        chk({tag, "_col"}, col, 0);
        chk({tag, "_row"}, row, 0);
        chk({tag, "_last"}, last, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
    endtask

    // Full frame on dut_a; optional stall at (stall_c,stall_r) and mid-frame start at (rs_c,rs_r).
    task automatic run_a(input int stall_c, input int stall_r, input int stall_len,
                         input int rs_c, input int rs_r);
        int dones = 0;
        bit got_last = 1'b0;
        bit stalled = 1'b0;
        bit wl;
        push_frame_a();
        start = 1'b1;
        out_ready = 1'b1;
        step();
        start = 1'b0;
        chk("latency_valid", out_valid, 1);
        for (int cyc = 0; cyc < 100 && !got_last; cyc++) begin
            if (out_valid && !stalled && col == stall_c && row == stall_r) begin
                stalled = 1'b1;
                out_ready = 1'b0;
                for (int k = 0; k < stall_len; k++) begin
                    step();
                    chk("stall_sel", select, sbq[0].sel);
                    chk("stall_col", col, sbq[0].col);
                    chk("stall_row", row, sbq[0].row);
                end
`ifdef KSEQ_STALL_CNT_EN
                chk("stall_cnt", stall_cnt, stall_len);
`endif
                out_ready = 1'b1;
            end
            if (done) dones++;
            if (out_valid && out_ready) begin
                start = (col == rs_c && row == rs_r);
                check_hs(wl);
                got_last = wl;
            end
            step();
            start = 1'b0;
        end
        chk("frame_completed", got_last, 1);
        chk("early_done", dones, 0);
        chk("done_pulse", done, 1);
        chk("done_valid_drop", out_valid, 0);
        chk("done_busy", busy, 1);
        step();
        chk("done_cleared", done, 0);
        chk("idle_busy", busy, 0);
        chk("sb_empty", sbq.size(), 0);
    endtask

    initial begin
        bit wl;
        pos_t p;
        int   tab_b[4] = '{1, 2, 3, 4};
        int   nb;

        #12;
        chk_reset_outputs("reset");
`ifdef KSEQ_STALL_CNT_EN
        chk("reset_stall_cnt", stall_cnt, 0);
`endif
        @(posedge clk);
        #1;
        rst = 1'b0;

        run_a(-1, -1, 0, -1, -1);
        run_a(2, 1, 5, -1, -1);
        run_a(-1, -1, 0, 1, 1);

        // abort at (3,0)
        push_frame_a();
        start = 1'b1;
        step();
        start = 1'b0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            if (out_valid && col == 3 && row == 0) break;
            if (out_valid && out_ready) check_hs(wl);
            step();
        end
        chk("abort_reach_col", col, 3);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk_reset_outputs("abort");
        for (int k = 0; k < 3; k++) begin
            step();
            chk("abort_no_done", done, 0);
        end
        sbq.delete();
        run_a(-1, -1, 0, -1, -1);

        // abort and start together in IDLE
        abort = 1'b1;
        start = 1'b1;
        step();
        abort = 1'b0;
        start = 1'b0;
        chk("abort_start_valid", out_valid, 0);
        chk("abort_start_busy", busy, 0);
        step();
        chk("abort_start_valid2", out_valid, 0);

        // asynchronous reset mid-frame
        push_frame_a();
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k < 5; k++) begin
            check_hs(wl);
            step();
        end
        #2;
        rst = 1'b1;
        #1;
        chk_reset_outputs("async_rst");
`ifdef KSEQ_STALL_CNT_EN
        chk("async_rst_stall_cnt", stall_cnt, 0);
`endif
        step();
        step();
        rst = 1'b0;
        sbq.delete();
        run_a(-1, -1, 0, -1, -1);

        // 2x2 frame
        for (int i = 0; i < 4; i++) begin
            p.sel  = 4'(tab_b[i]);
            p.col  = 8'(i % 2);
            p.row  = 8'(i / 2);
            p.last = (i == 3);
            qb.push_back(p);
        end
        start_b = 1'b1;
        step();
        start_b = 1'b0;
        nb = 0;
        for (int cyc = 0; cyc < 20 && nb < 4; cyc++) begin
            if (valid_b && ready_b) begin
                if (qb.size() == 0) begin
                    chk("b_underflow", 32'd1, 32'd0);
                end else begin
                    p = qb.pop_front();
                    chk("b_sel", select_b, p.sel);
                    chk("b_col", col_b, p.col);
                    chk("b_row", row_b, p.row);
                    chk("b_last", last_b, p.last);
                end
                nb++;
            end
            step();
        end
        chk("b_count", nb, 4);
        chk("b_done", done_b, 1);
        chk("b_valid_drop", valid_b, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/kernel_pos_seq.md
KERNEL_POS_SEQ -- requirements
Module: kernel_pos_seq

Interface
REQ-001 Parameter IMG_W, default 8, image width in pixels; legal range 2..256.
REQ-002 Parameter IMG_H, default 8, image height in pixels; legal range 2..256.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  one-cycle frame start request.
REQ-006 abort  input  1  synchronous frame abort.
REQ-007 out_ready  input  1  downstream accepts the current position.
REQ-008 out_valid  output  1  select, col, row and last are valid.
REQ-009 select  output  4  kernel position code for the downstream weight mux.
REQ-010 col  output  8  current column, 0..IMG_W-1.
REQ-011 row  output  8  current row, 0..IMG_H-1.
REQ-012 last  output  1  current position is (IMG_W-1, IMG_H-1).
REQ-013 busy  output  1  high in the SCAN and DONE states.
REQ-014 done  output  1  one-cycle pulse after the last position is accepted.

Function
REQ-015 The FSM SHALL have three states, IDLE, SCAN and DONE, with IDLE as the reset state.
REQ-016 IDLE->SCAN on start=1; col and row load 0; out_valid rises the next cycle (1-cycle latency).
REQ-017 start SHALL be ignored in SCAN and DONE.
REQ-018 Handshake: a position is consumed only when out_valid=1 and out_ready=1.
REQ-019 During a stall (out_ready=0), select, col, row and last SHALL hold stable.
REQ-020 On each handshake col SHALL increment; at col=IMG_W-1 col SHALL wrap to 0 and row SHALL increment.
REQ-021 select SHALL be registered and SHALL always match the current col and row.
REQ-022 select encoding (r0 = first row, rL = last row, c0 = first column, cL = last column):
  - 0001 top-left (r0,c0); 0010 top-right (r0,cL).
  - 0011 bottom-left (rL,c0); 0100 bottom-right (rL,cL).
  - 0101 right (cL, not r0/rL); 0110 left (c0, not r0/rL).
  - 0111 top (r0, not c0/cL); 1000 bottom (rL, not c0/cL).
  - 0000 interior.
REQ-023 last SHALL be 1 only at col=IMG_W-1 and row=IMG_H-1.
REQ-024 A handshake with last=1 SHALL move SCAN->DONE; out_valid drops the next cycle.
REQ-025 DONE SHALL last one cycle with done=1, then return to IDLE.
REQ-026 abort=1 in SCAN or DONE SHALL go to IDLE next cycle, with no done pulse and all outputs at their reset values.
REQ-027 If abort and start are both high in IDLE, abort SHALL win and the block SHALL stay in IDLE.
REQ-028 A frame SHALL produce exactly IMG_W*IMG_H handshakes in raster order.

Reset
REQ-029 On rst=1, outputs SHALL immediately take: out_valid=0, select=0000, col=0, row=0, last=0, busy=0, done=0; state=IDLE.
REQ-030 Reset asserted mid-frame SHALL discard the frame; no done pulse SHALL follow reset release.
REQ-031 The first start SHALL be honoured on the first rising edge after rst deasserts.

Configuration
REQ-032 Macro KSEQ_STALL_CNT_EN, when defined, SHALL add output stall_cnt (16 bits).
REQ-033 stall_cnt SHALL count cycles with out_valid=1 and out_ready=0, SHALL saturate at 0xFFFF, and SHALL clear on start acceptance, rst or abort.
REQ-034 Without KSEQ_STALL_CNT_EN the port and its logic SHALL be absent; all other behaviour is identical.

Verification
REQ-035 IMG_W=4, IMG_H=3, out_ready=1, start pulse -> 12 handshakes; select sequence 1,7,7,2,6,0,0,5,3,8,8,4; done pulses one cycle after the 12th handshake.
REQ-036 Same config, out_ready low for 5 cycles at (col=2,row=1) -> select=0000, col=2, row=1 held all 5 cycles; stall_cnt=5 when the macro is defined.
REQ-037 start pulsed again mid-frame at (col=1,row=1) -> ignored; sequence continues unchanged and done occurs once.
REQ-038 abort at (col=3,row=0) -> next cycle out_valid=0, busy=0, no done; a new start restarts at (0,0) with select=0001.
REQ-039 rst asserted asynchronously mid-frame between clock edges -> outputs reach reset values before the next edge; no done after release.
REQ-040 IMG_W=2, IMG_H=2 -> select sequence 1,2,3,4; last=1 on the 4th position only.
